inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/common_pkg.sv | 14 +
 rtl/inst_fetch.sv | 149 ++++++++++++++
 tb/tb_inst_fetch.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared types for the instruction front end: fetch FSM state encoding and instruction width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package common_pkg;

  localparam int INST_WIDTH = 16;

  typedef enum logic [1:0] {
    S_FETCH_HI = 2'b00,
    S_FETCH_LO = 2'b01,
    S_HOLD     = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// Fetches 16-bit big-endian instructions as two byte reads and presents them with valid/ready.
// Latency: valid rises 2 cycles after fetch start with zero-wait memory; jump redirect restarts fetch next cycle.
// Backpressure: inst_ready_in=0 holds the output; fetch stalls (or fills a one-entry buffer when INST_FETCH_PREFETCH_EN is defined).
module inst_fetch
  import common_pkg::*;
#(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  output logic                  mem_req_out,
  output logic [PC_WIDTH:0]     mem_addr_out,
  input  logic                  mem_ack_in,
  input  logic [7:0]            mem_rdata_in,
  input  logic                  jump_en_in,
  input  logic [PC_WIDTH-1:0]   jump_addr_in,
  output logic                  inst_valid_out,
  input  logic                  inst_ready_in,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [PC_WIDTH-1:0]   pc_out
);

  fetch_state_t          state;
  logic [PC_WIDTH-1:0]   fetch_pc;
  logic [7:0]            hi_byte;
  logic                  accept;
  logic                  word_done;
  logic [INST_WIDTH-1:0] new_inst;

  assign accept    = inst_valid_out && inst_ready_in;
  assign word_done = (state == S_FETCH_LO) && mem_ack_in;
  assign new_inst  = {hi_byte, mem_rdata_in};

  // Request is combinational so a jump withdraws it in the same cycle and reset kills it at once.
  assign mem_req_out  = !rst_in && !jump_en_in && (state != S_HOLD);
  assign mem_addr_out = {fetch_pc, (state == S_FETCH_LO)};

`ifdef INST_FETCH_PREFETCH_EN
  logic                  pf_vld;
  logic [INST_WIDTH-1:0] pf_inst;
  logic [PC_WIDTH-1:0]   pf_pc;
  logic                  valid_nxt;
  logic                  pf_full_nxt;

  // Predict output/buffer occupancy after this edge; fetch parks in S_HOLD only when both are full.
  always_comb begin
    valid_nxt   = inst_valid_out || word_done;
    pf_full_nxt = pf_vld || (word_done && inst_valid_out);
    if (accept) begin
      valid_nxt   = pf_vld || word_done;
      pf_full_nxt = pf_vld && word_done;
    end
  end
`endif

  // Fetch FSM: byte sequencing, pc increment (wraps naturally) and jump redirect.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= S_FETCH_HI;
      fetch_pc <= RESET_PC;
      hi_byte  <= 8'h00;
    end else if (jump_en_in) begin
      // Jump beats any ack or accept in the same cycle; the ack's byte is dropped.
      state    <= S_FETCH_HI;
      fetch_pc <= jump_addr_in;
    end else begin
      unique case (state)
        S_FETCH_HI: begin
          if (mem_ack_in) begin
            hi_byte <= mem_rdata_in;
            state   <= S_FETCH_LO;
          end
        end
        S_FETCH_LO: begin
          if (mem_ack_in) begin
            fetch_pc <= fetch_pc + PC_WIDTH'(1);
`ifdef INST_FETCH_PREFETCH_EN
            state    <= (valid_nxt && pf_full_nxt) ? S_HOLD : S_FETCH_HI;
`else
            state    <= S_HOLD;
`endif
          end
        end
        S_HOLD: begin
          if (accept) state <= S_FETCH_HI;
        end
        default: state <= S_FETCH_HI;
      endcase
    end
  end

  // Output slot (and prefetch buffer when built): load on word completion, drain on accept.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      inst_valid_out <= 1'b0;
      inst_out       <= '0;
      pc_out         <= RESET_PC;
`ifdef INST_FETCH_PREFETCH_EN
      pf_vld         <= 1'b0;
      pf_inst        <= '0;
      pf_pc          <= RESET_PC;
`endif
    end else if (jump_en_in) begin
      inst_valid_out <= 1'b0;
`ifdef INST_FETCH_PREFETCH_EN
      pf_vld         <= 1'b0;
`endif
    end else begin
`ifdef INST_FETCH_PREFETCH_EN
      if (accept) begin
        if (pf_vld) begin
          inst_out <= pf_inst;
          pc_out   <= pf_pc;
          pf_vld   <= word_done;
          if (word_done) begin
            pf_inst <= new_inst;
            pf_pc   <= fetch_pc;
          end
        end else if (word_done) begin
          inst_out <= new_inst;
          pc_out   <= fetch_pc;
        end else begin
          inst_valid_out <= 1'b0;
        end
      end else if (word_done) begin
        if (!inst_valid_out) begin
          inst_out       <= new_inst;
          pc_out         <= fetch_pc;
          inst_valid_out <= 1'b1;
        end else begin
          pf_inst <= new_inst;
          pf_pc   <= fetch_pc;
          pf_vld  <= 1'b1;
        end
      end
`else
      if (word_done) begin
        inst_out       <= new_inst;
        pc_out         <= fetch_pc;
        inst_valid_out <= 1'b1;
      end else if (accept) begin
        inst_valid_out <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a zero-wait byte memory model.
// Latency: n/a.
// Backpressure: driven directly through inst_ready_in.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [8:0]  mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst;
  logic [7:0]  pc;

  logic        ack_gate;
  logic        ack_force;
  logic [7:0]  mem [0:511];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Zero-wait memory: ack in the same cycle as the request; ack_force acks even without a request.
  assign mem_ack   = ack_gate && (mem_req || ack_force);
  assign mem_rdata = mem[mem_addr];

  inst_fetch #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .mem_req_out    (mem_req),
    .mem_addr_out   (mem_addr),
    .mem_ack_in     (mem_ack),
    .mem_rdata_in   (mem_rdata),
    .jump_en_in     (jump_en),
    .jump_addr_in   (jump_addr),
    .inst_valid_out (inst_valid),
    .inst_ready_in  (inst_ready),
    .inst_out       (inst),
    .pc_out         (pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[9'h000] = 8'h12; mem[9'h001] = 8'h34;
    mem[9'h002] = 8'h56; mem[9'h003] = 8'h78;
    mem[9'h004] = 8'h9A; mem[9'h005] = 8'hBC;
    mem[9'h080] = 8'h9A; mem[9'h081] = 8'hBC;
    mem[9'h1FE] = 8'hAB; mem[9'h1FF] = 8'hCD;

    rst = 1'b1; jump_en = 1'b0; jump_addr = 8'h00; inst_ready = 1'b0;
    ack_gate = 1'b1; ack_force = 1'b0;

    tick();
    chk("rst_req",   mem_req,    1'b0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst",  inst,       16'h0000);
    chk("rst_pc",    pc,         8'h00);
    rst = 1'b0;
    #1;
    chk("first_req",  mem_req,  1'b1);
    chk("first_addr", mem_addr, 9'h000);
    tick();
    chk("lo_addr",    mem_addr, 9'h001);
    chk("lo_valid",   inst_valid, 1'b0);
    tick();
    chk("w0_valid", inst_valid, 1'b1);
    chk("w0_inst",  inst,       16'h1234);
    chk("w0_pc",    pc,         8'h00);

`ifdef INST_FETCH_PREFETCH_EN
    // Buffer fills while the output is stalled, then drains with no valid gap.
    tick();
    chk("pf_req_lo", mem_addr, 9'h003);
    tick();
    chk("pf_full_req", mem_req, 1'b0);
    chk("pf_hold_inst", inst, 16'h1234);
    inst_ready = 1'b1;
    tick();
    chk("pf_b2b_valid", inst_valid, 1'b1);
    chk("pf_b2b_inst",  inst,       16'h5678);
    chk("pf_b2b_pc",    pc,         8'h01);
    chk("pf_next_addr", mem_addr,   9'h004);
    inst_ready = 1'b0;
`else
    // Stalled output: instruction stable, no requests.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_inst", inst,    16'h1234);
      chk("stall_req",  mem_req, 1'b0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("acc_valid", inst_valid, 1'b0);
    chk("acc_req",   mem_req,    1'b1);
    chk("acc_addr",  mem_addr,   9'h002);
    tick();
    tick();
    chk("w1_inst", inst, 16'h5678);
    chk("w1_pc",   pc,   8'h01);

    // Jump to 0xFF from S_HOLD, then check the increment wraps to 0.
    jump_en = 1'b1; jump_addr = 8'hFF;
    #1;
    chk("jmp_withdraw", mem_req, 1'b0);
    tick();
    jump_en = 1'b0;
    chk("jff_valid", inst_valid, 1'b0);
    chk("jff_addr",  mem_addr,   9'h1FE);
    tick();
    tick();
    chk("wff_inst", inst, 16'hABCD);
    chk("wff_pc",   pc,   8'hFF);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("wrap_addr", mem_addr, 9'h000);
    tick();
    tick();
    chk("wrap_pc",   pc,   8'h00);
    chk("wrap_inst", inst, 16'h1234);

    // Jump during S_FETCH_LO with a simultaneous ack: ack must be discarded.
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    tick();
    chk("pre_jlo_addr", mem_addr, 9'h003);
    jump_en = 1'b1; jump_addr = 8'h40; ack_force = 1'b1;
    tick();
    jump_en = 1'b0; ack_force = 1'b0;
    chk("j40_addr",  mem_addr,   9'h080);
    chk("j40_valid", inst_valid, 1'b0);
    chk("j40_inst",  inst,       16'h1234);
    tick();
    chk("j40_lo_addr", mem_addr, 9'h081);
    tick();
    chk("w40_inst", inst, 16'h9ABC);
    chk("w40_pc",   pc,   8'h40);

    // Reset asserted mid S_FETCH_LO drops the request before the next edge.
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    tick();
    chk("pre_rst_req", mem_req, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req",   mem_req,    1'b0);
    chk("mid_rst_valid", inst_valid, 1'b0);
    chk("mid_rst_addr",  mem_addr,   9'h000);
    tick();
    rst = 1'b0;
    #1;
    chk("rerun_req", mem_req, 1'b1);
    tick();
    tick();
    chk("rerun_inst", inst, 16'h1234);
    chk("rerun_pc",   pc,   8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
